// File: rtl/iob_pkg.sv
// -----------------------------------------------------------------------------
// iob_pkg -- shared types and constants for the I/O bus master.
//
// Contents:
//   state_t      bus-cycle state machine encoding (IDLE, S0..S7, HOLD)
//   E_*          E-clock generator constants (period, high phase, VPA point)
//   TMO_*        S4 timeout counter width and limit (IOB_TIMEOUT_EN builds)
//   state_in()   inclusive range test on the state encoding
// -----------------------------------------------------------------------------
package iob_pkg;

    // S0..S7 are encoded consecutively so strobe windows can be expressed
    // as simple inclusive ranges.
    typedef enum logic [3:0] {
        IDLE = 4'd0,
        S0   = 4'd1,
        S1   = 4'd2,
        S2   = 4'd3,
        S3   = 4'd4,
        S4   = 4'd5,
        S5   = 4'd6,
        S6   = 4'd7,
        S7   = 4'd8,
        HOLD = 4'd9
    } state_t;

    // E clock: ten CLK periods, low for counts 0..5, high for 6..9.
    localparam int              E_W          = 4;
    localparam logic [E_W-1:0]  E_PERIOD     = 4'd10;
    localparam logic [E_W-1:0]  E_HIGH_START = 4'd6;
    localparam logic [E_W-1:0]  E_VPA_TERM   = 4'd8;

    // S4 watchdog.
    localparam int               TMO_W   = 8;
    localparam logic [TMO_W-1:0] TMO_MAX = 8'd255;

    function automatic logic state_in(input state_t s, input state_t lo, input state_t hi);
        return (s >= lo) && (s <= hi);
    endfunction

endpackage

// File: rtl/iob_eclk.sv
// -----------------------------------------------------------------------------
// iob_eclk -- 68000-style E clock generator.
//
// A free-running modulo-10 counter; E is high for counts 6..9 (6 low / 4 high).
//
// Ports:
//   CLK   in   system clock (one S-state per period)
//   nRST  in   asynchronous active-low reset
//   Ecnt  out  current E phase, 0..9
//   Eout  out  E clock, registered and aligned with Ecnt
// -----------------------------------------------------------------------------
module iob_eclk
    import iob_pkg::*;
(
    input  logic           CLK,
    input  logic           nRST,
    output logic [E_W-1:0] Ecnt,
    output logic           Eout
);

    logic [E_W-1:0] w_ecnt_nxt;

    always_comb begin
        if (Ecnt == E_PERIOD - 4'd1) begin
            w_ecnt_nxt = '0;
        end else begin
            w_ecnt_nxt = Ecnt + 4'd1;
        end
    end

    // Eout is decoded from the next count so that it changes on the same
    // edge as Ecnt and never glitches.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            Ecnt <= '0;
            Eout <= 1'b0;
        end else begin
            Ecnt <= w_ecnt_nxt;
            Eout <= (w_ecnt_nxt >= E_HIGH_START);
        end
    end

endmodule

// File: rtl/iob_master.sv
// -----------------------------------------------------------------------------
// iob_master -- 68000 bus master driven by an I/O slave request FIFO.
//
// Runs one asynchronous 68000 bus cycle (S0..S7) per request and hands the
// result back to the slave through IOACT/IOBERR. S4 is stretched until the
// bus is terminated by BERR, DTACK or VPA (VPA aligned to the E clock).
//
// Optional feature (macro IOB_TIMEOUT_EN): an 8-bit S4 watchdog that ends the
// cycle with an error after 256 CLK in S4. Without the macro S4 waits forever.
//
// Ports:
//   CLK, nRST        clock (one S-state per period), async active-low reset
//   IOREQ            cycle request from slave (asynchronous)
//   IORW0            1 = read, 0 = write
//   IOL0, IOU0       lower / upper byte enables
//   nDTACKin         data acknowledge, active-low (asynchronous)
//   nVPAin           valid peripheral address, active-low (asynchronous)
//   nBERRin          bus error, active-low (asynchronous)
//   IOACT            cycle active / acknowledge to slave
//   IOBERR           error status of the last completed cycle
//   nASout           address strobe
//   nLDSout/nUDSout  lower / upper data strobes
//   nRWout           bus direction (0 = write)
//   nDoutOE          write-data output enable
//   Eout             E clock
// -----------------------------------------------------------------------------
module iob_master
    import iob_pkg::*;
(
    input  logic CLK,
    input  logic nRST,
    input  logic IOREQ,
    input  logic IORW0,
    input  logic IOL0,
    input  logic IOU0,
    input  logic nDTACKin,
    input  logic nVPAin,
    input  logic nBERRin,
    output logic IOACT,
    output logic IOBERR,
    output logic nASout,
    output logic nLDSout,
    output logic nUDSout,
    output logic nRWout,
    output logic nDoutOE,
    output logic Eout
);

    // -------------------------------------------------------------------------
    // Two-flop synchronizers. Idle levels: request 0, active-low inputs 1.
    // -------------------------------------------------------------------------
    logic r_ioreq_m, r_ioreqr;
    logic r_dtack_m, r_dtackr;
    logic r_vpa_m,   r_vpar;
    logic r_berr_m,  r_berrr;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ioreq_m <= 1'b0;
            r_ioreqr  <= 1'b0;
            r_dtack_m <= 1'b1;
            r_dtackr  <= 1'b1;
            r_vpa_m   <= 1'b1;
            r_vpar    <= 1'b1;
            r_berr_m  <= 1'b1;
            r_berrr   <= 1'b1;
        end else begin
            r_ioreq_m <= IOREQ;
            r_ioreqr  <= r_ioreq_m;
            r_dtack_m <= nDTACKin;
            r_dtackr  <= r_dtack_m;
            r_vpa_m   <= nVPAin;
            r_vpar    <= r_vpa_m;
            r_berr_m  <= nBERRin;
            r_berrr   <= r_berr_m;
        end
    end

    // -------------------------------------------------------------------------
    // E clock generator
    // -------------------------------------------------------------------------
    logic [E_W-1:0] w_ecnt;

    iob_eclk u_eclk (
        .CLK  (CLK),
        .nRST (nRST),
        .Ecnt (w_ecnt),
        .Eout (Eout)
    );

    // -------------------------------------------------------------------------
    // Cycle state and latched request attributes
    // -------------------------------------------------------------------------
    state_t r_state;
    state_t w_state_nxt;
    logic   w_err_set;
    logic   r_rw;
    logic   r_lds;
    logic   r_uds;
    logic   r_err;

`ifdef IOB_TIMEOUT_EN
    logic [TMO_W-1:0] r_tcnt;
`endif

    // Next-state decode. S4 termination sources are checked in priority
    // order: bus error, DTACK, VPA on the E phase, then (optionally) timeout.
    // HOLD only returns to IDLE once the request has been withdrawn, so a
    // request that stays high across HOLD cannot start a second cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        unique case (r_state)
            IDLE: if (r_ioreqr) w_state_nxt = S0;
            S0:   w_state_nxt = S1;
            S1:   w_state_nxt = S2;
            S2:   w_state_nxt = S3;
            S3:   w_state_nxt = S4;
            S4: begin
                if (!r_berrr) begin
                    w_state_nxt = S5;
                    w_err_set   = 1'b1;
                end else if (!r_dtackr) begin
                    w_state_nxt = S5;
                end else if (!r_vpar && (w_ecnt == E_VPA_TERM)) begin
                    w_state_nxt = S5;
`ifdef IOB_TIMEOUT_EN
                end else if (r_tcnt == TMO_MAX) begin
                    w_state_nxt = S5;
                    w_err_set   = 1'b1;
`endif
                end
            end
            S5:   w_state_nxt = S6;
            S6:   w_state_nxt = S7;
            S7:   w_state_nxt = HOLD;
            HOLD: if (!r_ioreqr) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Strobe windows for the state being entered; outputs are registered
    // from these so every strobe changes exactly on the state edge.
    logic w_as_win;
    logic w_ds_win;
    logic w_rw_win;
    logic w_oe_win;

    always_comb begin
        w_as_win = state_in(w_state_nxt, S2, S6);
        w_rw_win = state_in(w_state_nxt, S1, S7);
        w_oe_win = state_in(w_state_nxt, S2, S7);
        // Reads present data strobes with AS; writes wait until data is
        // stable on the bus (S4).
        w_ds_win = r_rw ? w_as_win : state_in(w_state_nxt, S4, S6);
    end

    // The direction and byte enables used below are latched on S0 entry and
    // are therefore already valid when S1 and later states are decoded.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_rw    <= 1'b1;
            r_lds   <= 1'b0;
            r_uds   <= 1'b0;
            r_err   <= 1'b0;
            IOACT   <= 1'b0;
            IOBERR  <= 1'b0;
            nASout  <= 1'b1;
            nLDSout <= 1'b1;
            nUDSout <= 1'b1;
            nRWout  <= 1'b1;
            nDoutOE <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            IOACT   <= (w_state_nxt != IDLE);

            if (w_state_nxt == S0) begin
                r_rw   <= IORW0;
                r_lds  <= IOL0;
                r_uds  <= IOU0;
                r_err  <= 1'b0;
                IOBERR <= 1'b0;
            end else begin
                if (w_err_set) begin
                    r_err <= 1'b1;
                end
                // Status is published only once the cycle has fully ended.
                if ((r_state == S7) && (w_state_nxt == HOLD)) begin
                    IOBERR <= r_err;
                end
            end

            nASout  <= ~w_as_win;
            nLDSout <= ~(w_ds_win & r_lds);
            nUDSout <= ~(w_ds_win & r_uds);
            nRWout  <= ~(w_rw_win & ~r_rw);
            nDoutOE <= ~(w_oe_win & ~r_rw);
        end
    end

`ifdef IOB_TIMEOUT_EN
    // Counts CLKs spent in S4 and sticks at the limit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_tcnt <= '0;
        end else if (w_state_nxt == S0) begin
            r_tcnt <= '0;
        end else if ((r_state == S4) && (r_tcnt != TMO_MAX)) begin
            r_tcnt <= r_tcnt + TMO_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_iob_master.sv
// -----------------------------------------------------------------------------
// tb_iob_master -- directed bench for iob_master.
//
// Inputs are driven and outputs sampled on the falling CLK edge. A modulo-10
// counter tracks the expected E phase from reset so VPA cycles can be placed
// at a chosen phase. Build with IOB_TIMEOUT_EN defined to exercise the S4
// watchdog; otherwise the bench confirms S4 waits indefinitely.
// -----------------------------------------------------------------------------
module tb_iob_master;

    logic CLK = 1'b0;
    logic nRST;
    logic IOREQ, IORW0, IOL0, IOU0;
    logic nDTACKin, nVPAin, nBERRin;
    logic IOACT, IOBERR, nASout, nLDSout, nUDSout, nRWout, nDoutOE, Eout;

    int n_vec = 0;
    int n_err = 0;

    iob_master u_dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .IOREQ    (IOREQ),
        .IORW0    (IORW0),
        .IOL0     (IOL0),
        .IOU0     (IOU0),
        .nDTACKin (nDTACKin),
        .nVPAin   (nVPAin),
        .nBERRin  (nBERRin),
        .IOACT    (IOACT),
        .IOBERR   (IOBERR),
        .nASout   (nASout),
        .nLDSout  (nLDSout),
        .nUDSout  (nUDSout),
        .nRWout   (nRWout),
        .nDoutOE  (nDoutOE),
        .Eout     (Eout)
    );

    always #5 CLK = ~CLK;

    // Expected E phase: 0 at reset, +1 per CLK, wraps 9 -> 0.
    int m_ecnt;
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) m_ecnt <= 0;
        else       m_ecnt <= (m_ecnt == 9) ? 0 : m_ecnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One complete bus cycle. term: 0 DTACK, 1 VPA, 2 BERR+DTACK, 3 none.
    // phase >= 0 delays the request until the E phase equals that value.
    // Counts are CLKs each strobe spends low between S0 and cycle end.
    task automatic run_cycle(
        input  logic rw, input logic l, input logic u,
        input  int   term, input int phase, input int max_cyc,
        output int   as_n, output int lds_n, output int uds_n,
        output int   rw_n, output int oe_n, output int exit_ecnt,
        output int   berr_s0, output int berr_exit, output int berr_hold,
        output bit   timed_out
    );
        int lat;
        bit seen_as, done, act_ok, hold_ok;
        as_n = 0; lds_n = 0; uds_n = 0; rw_n = 0; oe_n = 0;
        exit_ecnt = -1; berr_exit = -1; berr_hold = -1; timed_out = 1'b0;
        if (phase >= 0) begin
            for (int i = 0; i < 20 && m_ecnt != phase; i++) @(negedge CLK);
        end
        IORW0 = rw; IOL0 = l; IOU0 = u; IOREQ = 1'b1;
        lat = 0;
        while (IOACT !== 1'b1 && lat < 10) begin
            @(negedge CLK);
            lat++;
        end
        check("ioact_latency_2to3", (lat >= 2 && lat <= 3), 1);
        berr_s0 = IOBERR;
        case (term)
            0: nDTACKin = 1'b0;
            1: nVPAin   = 1'b0;
            2: begin nDTACKin = 1'b0; nBERRin = 1'b0; end
            default: ;
        endcase
        act_ok = 1'b1; seen_as = 1'b0; done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge CLK);
            if (IOACT !== 1'b1) act_ok = 1'b0;
            if (nASout  === 1'b0) begin as_n++; seen_as = 1'b1; end
            if (nLDSout === 1'b0) lds_n++;
            if (nUDSout === 1'b0) uds_n++;
            if (nRWout  === 1'b0) rw_n++;
            if (nDoutOE === 1'b0) oe_n++;
            if (seen_as && nASout === 1'b1 && nLDSout === 1'b1 && nUDSout === 1'b1 &&
                nRWout === 1'b1 && nDoutOE === 1'b1) begin
                done = 1'b1;
                exit_ecnt = m_ecnt;
                berr_exit = IOBERR;
            end
        end
        if (!done) begin
            timed_out = 1'b1;
            return;
        end
        @(negedge CLK);
        berr_hold = IOBERR;
        check("ioact_high_through_cycle", act_ok, 1);
        nDTACKin = 1'b1; nVPAin = 1'b1; nBERRin = 1'b1;
        // Request still asserted: HOLD must not start another cycle.
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (IOACT !== 1'b1 || nASout !== 1'b1) hold_ok = 1'b0;
        end
        check("hold_no_restart", hold_ok, 1);
        IOREQ = 1'b0;
        lat = 0;
        while (IOACT !== 1'b0 && lat < 10) begin
            @(negedge CLK);
            lat++;
        end
        check("hold_to_idle_clks", lat, 3);
    endtask

    int as_n, lds_n, uds_n, rw_n, oe_n, exit_ecnt, berr_s0, berr_exit, berr_hold;
    bit timed_out;
    int n, lat, e_high;
    bit quiet;

    initial begin
        IOREQ = 1'b0; IORW0 = 1'b1; IOL0 = 1'b0; IOU0 = 1'b0;
        nDTACKin = 1'b1; nVPAin = 1'b1; nBERRin = 1'b1;
        nRST = 1'b1;

        // ---- reset state ----
        #3 nRST = 1'b0;
        #1;
        check("rst_IOACT", IOACT, 0);
        check("rst_IOBERR", IOBERR, 0);
        check("rst_nASout", nASout, 1);
        check("rst_nLDSout", nLDSout, 1);
        check("rst_nUDSout", nUDSout, 1);
        check("rst_nRWout", nRWout, 1);
        check("rst_nDoutOE", nDoutOE, 1);
        check("rst_Eout", Eout, 0);
        repeat (3) @(negedge CLK);
        nRST = 1'b1;

        // ---- E clock: low for phases 0..5, high for 6..9 ----
        e_high = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            check("eout_phase", Eout, (m_ecnt >= 6) ? 1 : 0);
            if (Eout === 1'b1) e_high++;
        end
        check("eout_high_per_20clk", e_high, 8);

        // ---- read word, DTACK ----
        run_cycle(1'b1, 1'b1, 1'b1, 0, -1, 100, as_n, lds_n, uds_n, rw_n, oe_n,
                  exit_ecnt, berr_s0, berr_exit, berr_hold, timed_out);
        check("rd_nAS_low", as_n, 5);
        check("rd_nLDS_low", lds_n, 5);
        check("rd_nUDS_low", uds_n, 5);
        check("rd_nRW_low", rw_n, 0);
        check("rd_nDoutOE_low", oe_n, 0);
        check("rd_IOBERR_hold", berr_hold, 0);

        // ---- write lower byte, DTACK ----
        run_cycle(1'b0, 1'b1, 1'b0, 0, -1, 100, as_n, lds_n, uds_n, rw_n, oe_n,
                  exit_ecnt, berr_s0, berr_exit, berr_hold, timed_out);
        check("wr_nAS_low", as_n, 5);
        check("wr_nLDS_low", lds_n, 3);
        check("wr_nUDS_low", uds_n, 0);
        check("wr_nRW_low", rw_n, 7);
        check("wr_nDoutOE_low", oe_n, 6);

        // ---- bus error wins over DTACK ----
        run_cycle(1'b1, 1'b1, 1'b1, 2, -1, 100, as_n, lds_n, uds_n, rw_n, oe_n,
                  exit_ecnt, berr_s0, berr_exit, berr_hold, timed_out);
        check("berr_nAS_low", as_n, 5);
        check("berr_IOBERR_in_S7", berr_exit, 0);
        check("berr_IOBERR_in_HOLD", berr_hold, 1);
        check("berr_IOBERR_in_IDLE", IOBERR, 1);

        // ---- VPA, S4 entered at E phase 1 (request at phase 4) ----
        run_cycle(1'b1, 1'b1, 1'b0, 1, 4, 100, as_n, lds_n, uds_n, rw_n, oe_n,
                  exit_ecnt, berr_s0, berr_exit, berr_hold, timed_out);
        check("vpa1_IOBERR_cleared_S0", berr_s0, 0);
        check("vpa1_nAS_low", as_n, 12);
        check("vpa1_nLDS_low", lds_n, 12);
        check("vpa1_nUDS_low", uds_n, 0);
        check("vpa1_ephase_at_S7", exit_ecnt, 1);
        check("vpa1_IOBERR_hold", berr_hold, 0);

        // ---- VPA, S4 entered at E phase 9 (request at phase 2) ----
        run_cycle(1'b1, 1'b1, 1'b1, 1, 2, 100, as_n, lds_n, uds_n, rw_n, oe_n,
                  exit_ecnt, berr_s0, berr_exit, berr_hold, timed_out);
        check("vpa9_nAS_low", as_n, 14);
        check("vpa9_ephase_at_S7", exit_ecnt, 1);

        // ---- no termination ----
`ifdef IOB_TIMEOUT_EN
        run_cycle(1'b1, 1'b1, 1'b1, 3, -1, 2000, as_n, lds_n, uds_n, rw_n, oe_n,
                  exit_ecnt, berr_s0, berr_exit, berr_hold, timed_out);
        check("tmo_cycle_ended", timed_out, 0);
        check("tmo_nAS_low", as_n, 260);
        check("tmo_IOBERR_hold", berr_hold, 1);
`else
        run_cycle(1'b1, 1'b1, 1'b1, 3, -1, 1000, as_n, lds_n, uds_n, rw_n, oe_n,
                  exit_ecnt, berr_s0, berr_exit, berr_hold, timed_out);
        check("notmo_still_waiting", timed_out, 1);
        check("notmo_nAS_still_low", nASout, 0);
        nRST = 1'b0;
        IOREQ = 1'b0;
        #1;
        check("notmo_rst_nAS", nASout, 1);
        check("notmo_rst_IOACT", IOACT, 0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        repeat (2) @(negedge CLK);
`endif

        // ---- reset asserted in S5 of a word write ----
        IORW0 = 1'b0; IOL0 = 1'b1; IOU0 = 1'b1; IOREQ = 1'b1;
        lat = 0;
        while (IOACT !== 1'b1 && lat < 10) begin
            @(negedge CLK);
            lat++;
        end
        nDTACKin = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && n < 4; i++) begin
            @(negedge CLK);
            if (nASout === 1'b0) n++;
        end
        check("s5_reached", n, 4);
        check("s5_nRW_low", nRWout, 0);
        check("s5_nDoutOE_low", nDoutOE, 0);
        nRST = 1'b0;
        #1;
        check("rstS5_IOACT", IOACT, 0);
        check("rstS5_nASout", nASout, 1);
        check("rstS5_nLDSout", nLDSout, 1);
        check("rstS5_nUDSout", nUDSout, 1);
        check("rstS5_nRWout", nRWout, 1);
        check("rstS5_nDoutOE", nDoutOE, 1);
        check("rstS5_Eout", Eout, 0);
        nDTACKin = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (nASout !== 1'b1 || IOACT !== 1'b0 || nRWout !== 1'b1) quiet = 1'b0;
        end
        check("rstS5_bus_quiet", quiet, 1);
        nRST = 1'b1;
        lat = 0;
        while (IOACT !== 1'b1 && lat < 10) begin
            @(negedge CLK);
            lat++;
        end
        check("rstS5_restart_within_3", (lat >= 1 && lat <= 3), 1);
        nDTACKin = 1'b0;
        IOREQ = 1'b0;
        n = 0;
        while (IOACT !== 1'b0 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("rstS5_restart_completes", IOACT, 0);
        nDTACKin = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
